alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request operands/opcode valid.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port ALUCtl  input  4  opcode.
REQ-007 SHALL have ports rs1, rs2  input  XLEN  operands.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port ALUresult  output  XLEN  registered result.
REQ-011 SHALL have port zero  output  1  ALUresult == 0.
REQ-012 SHALL have port illegal  output  1  accepted opcode was unsupported.

Function
REQ-013 SHALL decode ALUCtl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL, 1001 SRA, 0111 SLT (signed), 1000 SLTU, 1010 MUL (low XLEN bits of product); all others illegal.
REQ-014 SHALL perform ADD/SUB modulo 2^XLEN; shift amount = rs2[$clog2(XLEN)-1:0], upper bits ignored; SLT/SLTU result is 0 or 1 zero-extended.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready); handshake occurs when in_valid and in_ready high at a rising edge.
REQ-017 SHALL, on accepting a non-MUL or illegal opcode, register result and flags and enter DONE; out_valid high the next cycle (latency 1).
REQ-018 SHALL, on accepting MUL, capture operands, enter BUSY, perform one shift-add step per cycle for XLEN cycles, then enter DONE (out_valid exactly XLEN+1 cycles after acceptance).
REQ-019 SHALL hold ALUresult, zero, illegal, out_valid stable in DONE until out_ready high.
REQ-020 SHALL, in DONE with out_ready high and no new handshake, return to IDLE with out_valid low next cycle.
REQ-021 SHALL, in DONE with out_ready and a simultaneous new handshake, complete the old transfer and accept the new request in the same edge (back-to-back single-cycle ops sustain 1 result/cycle).
REQ-022 SHALL ignore in_valid, ALUCtl, rs1, rs2 while BUSY (in_ready low).
REQ-023 SHALL, for an illegal opcode, produce ALUresult = 0, zero = 1, illegal = 1; illegal = 0 for all legal results.
REQ-024 SHALL compute zero from the final registered result for every opcode (never X).

Reset
REQ-025 SHALL, when rst high at a rising edge, enter IDLE and clear out_valid, ALUresult, zero, illegal, and MUL accumulator/counter to 0, overriding any handshake that cycle.
REQ-026 SHALL abort an in-progress MUL on reset with no result emitted; in_ready high the cycle after rst deasserts.

Configuration
REQ-027 SHALL compile the iterative multiplier (BUSY state, accumulator, counter) only when macro ALU_MC_MUL_EN is defined.
REQ-028 SHALL, without ALU_MC_MUL_EN, treat opcode 1010 as illegal (REQ-023), omit BUSY, and give every opcode latency 1.

Verification
REQ-029 Reset then ADD rs1=0x00000005, rs2=0x00000003, out_ready=1 -> next cycle out_valid=1, ALUresult=0x00000008, zero=0, illegal=0.
REQ-030 SUB rs1=rs2=0x12345678 -> ALUresult=0, zero=1; SLT rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 0x24 -> 0xF8000000.
REQ-031 With ALU_MC_MUL_EN, MUL rs1=0x00010001, rs2=0x00010001 -> in_ready low 32 cycles, out_valid at cycle 33, ALUresult=0x00020001; without macro -> illegal=1, ALUresult=0, latency 1.
REQ-032 Stream AND, OR, XOR back-to-back with out_ready=1 -> one result per cycle in order; then hold out_ready=0 for 3 cycles -> outputs stable, in_ready low.
REQ-033 Opcode 1111 -> illegal=1, zero=1, ALUresult=0; next legal op -> illegal=0.
REQ-034 Assert rst at cycle 10 of a MUL -> no out_valid, all outputs 0, next request accepted normally.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - ALU with valid/ready handshake and optional iterative multiplier (ALU_MC_MUL_EN)
module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUCtl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUresult,
    output logic            zero,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam int         CW      = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [CW-1:0]   cnt;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] res;
    logic            ill;
    logic [SW-1:0]   shamt;
    logic            accept;

    assign shamt     = rs2[SW-1:0];
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // Single-cycle datapath; unsupported opcodes fall to an all-zero result.
    always_comb begin
        res = '0;
        ill = 1'b0;
        case (ALUCtl)
            OP_AND:  res = rs1 & rs2;
            OP_OR:   res = rs1 | rs2;
            OP_ADD:  res = rs1 + rs2;
            OP_SUB:  res = rs1 - rs2;
            OP_XOR:  res = rs1 ^ rs2;
            OP_SLL:  res = rs1 << shamt;
            OP_SRL:  res = rs1 >> shamt;
            OP_SRA:  res = $signed(rs1) >>> shamt;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, rs1 < rs2};
            default: begin
                res = '0;
                ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ALUresult <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef ALU_MC_MUL_EN
                        if (ALUCtl == OP_MUL) begin
                            mcand  <= rs1;
                            mplier <= rs2;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= BUSY;
                        end else begin
                            ALUresult <= res;
                            zero      <= (res == '0);
                            illegal   <= ill;
                            state     <= DONE;
                        end
`else
                        ALUresult <= res;
                        zero      <= (res == '0);
                        illegal   <= ill;
                        state     <= DONE;
`endif
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
`ifdef ALU_MC_MUL_EN
                // One shift-add step per cycle; the last step lands directly in DONE.
                BUSY: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    acc    <= acc_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        ALUresult <= acc_next;
                        zero      <= (acc_next == '0);
                        illegal   <= 1'b0;
                        state     <= DONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (vector table + scoreboard)
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUCtl;
    logic [31:0] rs1, rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUresult;
    logic        zero;
    logic        illegal;

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    alu_mc #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUCtl(ALUCtl), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
        .out_ready(out_ready), .ALUresult(ALUresult), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every result transfer pops and compares one expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_result: got 0x%08h expected none at %0t", ALUresult, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", ALUresult, e.res);
                chk("zero", {31'b0, zero}, {31'b0, (e.res == 32'h0)});
                chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic il, output int waited);
        in_valid = 1'b1;
        ALUCtl   = c;
        rs1      = a;
        rs2      = b;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            nchk++;
            nfail++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 at %0t", $time);
        end else begin
            sb.push_back('{r, il});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] hold_res;
        logic        hold_zero, hold_ill;
        logic        seen;
        logic [31:0] mul_res;
        logic        mul_ill;

`ifdef ALU_MC_MUL_EN
        mul_res = 32'h0002_0001;
        mul_ill = 1'b0;
`else
        mul_res = 32'h0;
        mul_ill = 1'b1;
`endif

        vecs.push_back('{4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0});
        vecs.push_back('{4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0});
        vecs.push_back('{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
        vecs.push_back('{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0});
        vecs.push_back('{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
        vecs.push_back('{4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0});
        vecs.push_back('{4'b0100, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0});
        vecs.push_back('{4'b0101, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0});
        vecs.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{4'b1111, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b1});
        vecs.push_back('{4'b0010, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0});
        vecs.push_back('{4'b1011, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{4'b0000, 32'hFFFF_FFFF, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0});

        rst = 1'b1; in_valid = 1'b0; ALUCtl = 4'h0; rs1 = '0; rs2 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_result", ALUresult, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'h0);
        chk("rst_illegal", {31'b0, illegal}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // Back-to-back single-cycle ops: each must be accepted without waiting.
        foreach (vecs[i]) begin
            send(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill, w);
            chk($sformatf("accept_wait_%0d", i), w, 32'h0);
            chk($sformatf("latency_%0d", i), {31'b0, out_valid}, 32'h1);
        end
        @(posedge clk); #1;
        chk("idle_after_drain", {31'b0, out_valid}, 32'h0);

        // Consumer stall: outputs hold and no new request is accepted.
        out_ready = 1'b0;
        send(4'b0011, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FF0_0FF0, 1'b0, w);
        hold_res = ALUresult; hold_zero = zero; hold_ill = illegal;
        in_valid = 1'b1; ALUCtl = 4'b0010; rs1 = 32'h1; rs2 = 32'h1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_result", ALUresult, 32'h0FF0_0FF0);
            chk("stall_flags", {30'b0, zero, illegal}, {30'b0, hold_zero, hold_ill});
            @(posedge clk); #1;
        end
        chk("stall_hold", ALUresult, hold_res);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", {31'b0, out_valid}, 32'h0);

        // Multiply: stray requests while busy must be ignored.
        send(4'b1010, 32'h0001_0001, 32'h0001_0001, mul_res, mul_ill, w);
`ifdef ALU_MC_MUL_EN
        for (int k = 0; k < 32; k++) begin
            in_valid = (k < 31);
            ALUCtl = 4'b0010; rs1 = $urandom; rs2 = $urandom;
            chk($sformatf("mul_busy_ready_%0d", k), {31'b0, in_ready}, 32'h0);
            chk($sformatf("mul_busy_valid_%0d", k), {31'b0, out_valid}, 32'h0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mul_done_valid", {31'b0, out_valid}, 32'h1);
`else
        chk("mul_latency", {31'b0, out_valid}, 32'h1);
`endif
        @(posedge clk); #1;

        // Reset in the middle of a multiply discards it.
        out_ready = 1'b0;
        send(4'b1010, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, mul_ill, w);
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        chk("midrst_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_result", ALUresult, 32'h0);
        chk("midrst_flags", {30'b0, zero, illegal}, 32'h0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst_no_result", {31'b0, seen}, 32'h0);
        send(4'b0010, 32'h0000_0007, 32'h0000_0008, 32'h0000_000F, 1'b0, w);
        chk("post_rst_accept", w, 32'h0);
        chk("post_rst_latency", {31'b0, out_valid}, 32'h1);

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_empty", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
